cache_nway: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate cache for instruction and data paths.
- Explicit miss FSM with three states: IDLE, EVICT, FILL.
- Victim selection is invalid-first, then round-robin per set.
- Sits between the pipeline memory stage and the line-wide memory arbiter, which uses a req/ack handshake.

---
 rtl/cache_nway_if.sv | 35 +++
 rtl/cache_nway.sv | 166 ++++++++++++++++
 tb/tb_cache_nway.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_if.sv
// cache_nway_if: pipeline-side request bus plus the line-wide req/ack handshake to the memory arbiter.
// The cache takes the slave modport; the pipeline/arbiter side takes master.
interface cache_nway_if #(parameter int WIDTH = 128);
   logic [31:0]      addr;
   logic             read_write;
   logic             master_enable;
   logic [3:0]       byte_enable;
   logic [31:0]      data_in;
   logic [31:0]      data_out;
   logic             hit;
   logic             mem_write_req;
   logic [31:0]      mem_write_addr;
   logic [WIDTH-1:0] mem_write_data;
   logic             mem_write_ack;
   logic             mem_read_req;
   logic [31:0]      mem_read_addr;
   logic [WIDTH-1:0] mem_read_data;
   logic             mem_read_ack;
   modport slave (
      input  addr, read_write, master_enable, byte_enable, data_in,
      output data_out, hit,
      output mem_write_req, mem_write_addr, mem_write_data,
      input  mem_write_ack,
      output mem_read_req, mem_read_addr,
      input  mem_read_data, mem_read_ack
   );
   modport master (
      output addr, read_write, master_enable, byte_enable, data_in,
      input  data_out, hit,
      input  mem_write_req, mem_write_addr, mem_write_data,
      output mem_write_ack,
      input  mem_read_req, mem_read_addr,
      output mem_read_data, mem_read_ack
   );
endinterface

// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back/write-allocate cache with IDLE/EVICT/FILL miss FSM.
// Defining CACHE_STATS_EN adds stat_hits/stat_misses/stat_evicts counters.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif
`ifndef INFO
`define INFO(msg)
`endif
module cache_nway #(
   parameter int    WIDTH = `MEMORY_WIDTH,
   parameter int    DEPTH = 4,
   parameter int    WAYS  = 4,
   parameter string ALIAS = "Cache"
) (
   input  logic        clk,
   input  logic        reset,
`ifdef CACHE_STATS_EN
   output logic [31:0] stat_hits,
   output logic [31:0] stat_misses,
   output logic [31:0] stat_evicts,
`endif
   cache_nway_if.slave bus
);
   localparam int WB  = $clog2(WIDTH / 8);
   localparam int DB  = $clog2(DEPTH);
   localparam int TB  = 32 - WB - DB;
   localparam int NW  = WIDTH / 32;
   localparam int WSB = NW > 1 ? $clog2(NW) : 1;
   localparam int VB  = WAYS > 1 ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, EVICT, FILL} state_t;
   state_t state, state_n;

   logic [WIDTH-1:0] line_q [WAYS][DEPTH];
   logic [TB-1:0]    tag_q [WAYS][DEPTH];
   logic [DEPTH-1:0] valid_q [WAYS];
   logic [DEPTH-1:0] dirty_q [WAYS];
   logic [VB-1:0]    rr_q [DEPTH];

   logic [DB-1:0]    idx, lat_idx;
   logic [TB-1:0]    tag, lat_tag;
   logic [WSB-1:0]   wsel;
   logic [VB-1:0]    hit_way, victim, lat_way;
   logic             any_hit, any_invalid, ev_dirty, lat_rr;
   logic             do_hit, do_miss, do_fill;
   logic [WIDTH-1:0] hit_line, merged_line;
   logic [31:0]      word, mask, merged;

   assign idx  = bus.addr[WB +: DB];
   assign tag  = bus.addr[WB + DB +: TB];
   assign wsel = NW > 1 ? bus.addr[2 +: WSB] : '0;

   // Descending scan so the lowest-numbered invalid way wins the victim slot.
   always_comb begin
      any_hit     = 1'b0;
      any_invalid = 1'b0;
      hit_way     = '0;
      victim      = rr_q[idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
            any_hit = 1'b1;
            hit_way = VB'(w);
         end
         if (!valid_q[w][idx]) begin
            any_invalid = 1'b1;
            victim      = VB'(w);
         end
      end
      hit_line    = line_q[hit_way][idx];
      word        = hit_line[wsel * 32 +: 32];
      mask        = {{8{bus.byte_enable[3]}}, {8{bus.byte_enable[2]}},
                     {8{bus.byte_enable[1]}}, {8{bus.byte_enable[0]}}};
      merged      = (word & ~mask) | (bus.data_in & mask);
      merged_line = hit_line;
      merged_line[wsel * 32 +: 32] = merged;
      ev_dirty    = !any_invalid && dirty_q[victim][idx];
   end

   always_comb begin
      do_hit  = state == IDLE && bus.master_enable && any_hit;
      do_miss = state == IDLE && bus.master_enable && !any_hit;
      do_fill = state == FILL && bus.mem_read_ack;
      state_n = state == IDLE  ? (do_miss ? (ev_dirty ? EVICT : FILL) : IDLE)
              : state == EVICT ? (bus.mem_write_ack ? FILL : EVICT)
              : (bus.mem_read_ack ? IDLE : FILL);
   end

   always_ff @(posedge clk)
      state <= reset ? IDLE : state_n;

   always_ff @(posedge clk) begin
      if (!reset && do_hit && !bus.read_write)
         line_q[hit_way][idx] <= merged_line;
      if (!reset && do_fill) begin
         line_q[lat_way][lat_idx] <= bus.mem_read_data;
         tag_q[lat_way][lat_idx]  <= lat_tag;
      end
      if (do_miss) begin
         lat_idx <= idx;
         lat_tag <= tag;
         lat_way <= victim;
         lat_rr  <= !any_invalid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
         end
         for (int i = 0; i < DEPTH; i++)
            rr_q[i] <= '0;
         bus.hit            <= 1'b0;
         bus.data_out       <= '0;
         bus.mem_write_req  <= 1'b0;
         bus.mem_write_addr <= '0;
         bus.mem_write_data <= '0;
         bus.mem_read_req   <= 1'b0;
         bus.mem_read_addr  <= '0;
`ifdef CACHE_STATS_EN
         stat_hits   <= '0;
         stat_misses <= '0;
         stat_evicts <= '0;
`endif
      end else begin
         bus.hit <= do_hit;
         if (do_hit) begin
            bus.data_out <= bus.read_write ? word : merged;
            if (!bus.read_write)
               dirty_q[hit_way][idx] <= 1'b1;
            `INFO(("[%s] hit way %0d set %0d", ALIAS, hit_way, idx));
         end
         if (do_miss) begin
            valid_q[victim][idx] <= 1'b0;
            if (ev_dirty) begin
               bus.mem_write_req  <= 1'b1;
               bus.mem_write_addr <= {tag_q[victim][idx], idx, {WB{1'b0}}};
               bus.mem_write_data <= line_q[victim][idx];
            end else begin
               bus.mem_read_req  <= 1'b1;
               bus.mem_read_addr <= {tag, idx, {WB{1'b0}}};
            end
            `INFO(("[%s] miss set %0d victim %0d", ALIAS, idx, victim));
         end
         if (state == EVICT && bus.mem_write_ack) begin
            bus.mem_write_req <= 1'b0;
            bus.mem_read_req  <= 1'b1;
            bus.mem_read_addr <= {lat_tag, lat_idx, {WB{1'b0}}};
         end
         if (do_fill) begin
            valid_q[lat_way][lat_idx] <= 1'b1;
            dirty_q[lat_way][lat_idx] <= 1'b0;
            bus.mem_read_req          <= 1'b0;
            if (lat_rr)
               rr_q[lat_idx] <= lat_way == VB'(WAYS - 1) ? '0 : lat_way + 1'b1;
            `INFO(("[%s] fill way %0d set %0d", ALIAS, lat_way, lat_idx));
         end
`ifdef CACHE_STATS_EN
         stat_hits   <= stat_hits + 32'(do_hit);
         stat_misses <= stat_misses + 32'(do_miss);
         stat_evicts <= stat_evicts + 32'(do_miss && ev_dirty);
`endif
      end
   end
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: directed scenarios then random traffic against a flat-memory view plus a per-set residency model.
module tb_cache_nway;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cache_nway_if #(.WIDTH(128)) bus ();
`ifdef CACHE_STATS_EN
   logic [31:0] stat_hits, stat_misses, stat_evicts;
`endif

   cache_nway #(.WIDTH(128), .DEPTH(4), .WAYS(4), .ALIAS("tb")) dut (
      .clk(clk),
      .reset(reset),
`ifdef CACHE_STATS_EN
      .stat_hits(stat_hits),
      .stat_misses(stat_misses),
      .stat_evicts(stat_evicts),
`endif
      .bus(bus)
   );

   int checks = 0;
   int fails = 0;
   logic [127:0] backing [logic [31:0]];
   logic [31:0]  flat [logic [31:0]];
   bit           m_valid [4][4];
   bit           m_dirty [4][4];
   logic [25:0]  m_tag [4][4];
   int           m_rr [4];
   int           m_hits, m_misses, m_evicts;
   logic [31:0]  last_dout;
   logic [31:0]  wb_seen;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0]  la;
      logic [127:0] l;
      la = {a[31:4], 4'h0};
      if (backing.exists(la)) begin
         l = backing[la];
         return l[a[3:2] * 32 +: 32];
      end
      return pat({a[31:2], 2'b00});
   endfunction

   function automatic logic [31:0] view_word(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      return flat.exists(k) ? flat[k] : mem_word(k);
   endfunction

   function automatic logic [127:0] view_line(input logic [31:0] la);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i * 32 +: 32] = view_word(la + 32'(4 * i));
      return l;
   endfunction

   function automatic logic [127:0] mem_line(input logic [31:0] la);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i * 32 +: 32] = mem_word(la + 32'(4 * i));
      return l;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < 4; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
            m_tag[s][w]   = '0;
         end
      end
      flat.delete();
      m_hits = 0;
      m_misses = 0;
      m_evicts = 0;
      last_dout = '0;
   endtask

   task automatic ack_pulse(input bit wr, input logic [127:0] line);
      int dly;
      dly = $urandom_range(0, 2);
      repeat (dly) begin
         @(posedge clk); #1;
         chk(wr ? "wb_req_held" : "rd_req_held", {bus.mem_write_req, bus.mem_read_req}, wr ? 2'b10 : 2'b01);
      end
      @(negedge clk);
      if (wr) bus.mem_write_ack = 1'b1;
      else begin
         bus.mem_read_data = line;
         bus.mem_read_ack  = 1'b1;
      end
      @(posedge clk); #1;
      bus.mem_write_ack = 1'b0;
      bus.mem_read_ack  = 1'b0;
   endtask

   task automatic access(input logic [31:0] a, input logic rd, input logic [3:0] be, input logic [31:0] d);
      int s, way, v;
      bit rr_pick;
      logic [25:0] t;
      logic [31:0] la, wa, mask, exp;
      s  = int'(a[5:4]);
      t  = a[31:6];
      la = {a[31:4], 4'h0};
      way = -1;
      for (int w = 0; w < 4; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
      @(negedge clk);
      bus.addr = a;
      bus.read_write = rd;
      bus.byte_enable = be;
      bus.data_in = d;
      bus.master_enable = 1'b1;
      if (way < 0) begin
         v = -1;
         for (int w = 0; w < 4; w++) if (!m_valid[s][w] && v < 0) v = w;
         rr_pick = v < 0;
         if (rr_pick) v = m_rr[s];
         m_misses++;
         @(posedge clk); #1;
         chk("miss_hit", bus.hit, 1'b0);
         if (m_valid[s][v] && m_dirty[s][v]) begin
            wa = {m_tag[s][v], 2'(s), 4'h0};
            m_evicts++;
            chk("wb_req", {bus.mem_write_req, bus.mem_read_req}, 2'b10);
            chk("wb_addr", bus.mem_write_addr, wa);
            chk("wb_data", bus.mem_write_data, view_line(wa));
            wb_seen = bus.mem_write_addr;
            backing[wa] = bus.mem_write_data;
            ack_pulse(1'b1, '0);
            chk("rd_after_wb", {bus.mem_write_req, bus.mem_read_req}, 2'b01);
         end else
            chk("rd_req", {bus.mem_write_req, bus.mem_read_req}, 2'b01);
         chk("rd_addr", bus.mem_read_addr, la);
         ack_pulse(1'b0, mem_line(la));
         chk("fill_done", {bus.mem_write_req, bus.mem_read_req, bus.hit}, 3'b000);
         m_valid[s][v] = 1;
         m_dirty[s][v] = 0;
         m_tag[s][v]   = t;
         if (rr_pick) m_rr[s] = (v + 1) % 4;
         way = v;
      end
      @(posedge clk); #1;
      chk("hit", bus.hit, 1'b1);
      m_hits++;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      exp  = rd ? view_word(a) : (view_word(a) & ~mask) | (d & mask);
      if (!rd) begin
         flat[{a[31:2], 2'b00}] = exp;
         m_dirty[s][way] = 1;
      end
      chk(rd ? "read_data" : "write_data", bus.data_out, exp);
      last_dout = exp;
      @(negedge clk);
      bus.master_enable = 1'b0;
   endtask

   initial begin
      bus.addr = '0;
      bus.read_write = 1'b1;
      bus.master_enable = 1'b0;
      bus.byte_enable = '0;
      bus.data_in = '0;
      bus.mem_write_ack = 1'b0;
      bus.mem_read_ack = 1'b0;
      bus.mem_read_data = '0;
      wb_seen = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", {bus.hit, bus.mem_write_req, bus.mem_read_req}, 3'b000);
      chk("rst_dout", bus.data_out, 32'h0);
      chk("rst_addrs", {bus.mem_write_addr, bus.mem_read_addr}, 64'h0);
      chk("rst_wdata", bus.mem_write_data, 128'h0);
      @(negedge clk);
      reset = 1'b0;

      backing[32'h100] = 128'h44444444_33333333_22222222_11111111;
      access(32'h100, 1'b1, 4'h0, 32'h0);
      chk("s1_word0", bus.data_out, 32'h11111111);
      access(32'h108, 1'b1, 4'h0, 32'h0);
      chk("s1_word2", bus.data_out, 32'h33333333);
      access(32'h104, 1'b0, 4'b0011, 32'hAABBCCDD);
      chk("s2_merge", bus.data_out, 32'h2222CCDD);

      access(32'h000, 1'b1, 4'h0, 32'h0);
      access(32'h040, 1'b1, 4'h0, 32'h0);
      access(32'h080, 1'b1, 4'h0, 32'h0);
      access(32'h0C0, 1'b1, 4'h0, 32'h0);
      chk("s3_wb_addr", wb_seen, 32'h100);
      access(32'h104, 1'b1, 4'h0, 32'h0);
      chk("s3_wb_roundtrip", bus.data_out, 32'h2222CCDD);

      access(32'h0C4, 1'b1, 4'h0, 32'h0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("s5_idle_ctl", {bus.hit, bus.mem_write_req, bus.mem_read_req}, 3'b000);
         chk("s5_idle_dout", bus.data_out, last_dout);
      end

      @(negedge clk);
      bus.addr = 32'h140;
      bus.read_write = 1'b1;
      bus.master_enable = 1'b1;
      @(posedge clk); #1;
      chk("s4_miss_req", {bus.mem_write_req, bus.mem_read_req, bus.hit}, 3'b010);
      chk("s4_rd_addr", bus.mem_read_addr, 32'h140);
      @(negedge clk);
      reset = 1'b1;
      bus.master_enable = 1'b0;
      @(posedge clk); #1;
      chk("s4_reset_ctl", {bus.mem_write_req, bus.mem_read_req, bus.hit}, 3'b000);
      chk("s4_reset_dout", bus.data_out, 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.mem_read_data = {4{32'hDEADBEEF}};
      bus.mem_read_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_read_ack = 1'b0;
      chk("s4_late_ack", {bus.mem_write_req, bus.mem_read_req, bus.hit}, 3'b000);
      access(32'h000, 1'b1, 4'h0, 32'h0);
      access(32'h104, 1'b1, 4'h0, 32'h0);
      chk("s4_after_reset", bus.data_out, 32'h2222CCDD);

      for (int n = 0; n < 200; n++)
         access(32'($urandom_range(0, 'h1FF)) & ~32'h3, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), $urandom);

`ifdef CACHE_STATS_EN
      chk("stat_hits", stat_hits, 32'(m_hits));
      chk("stat_misses", stat_misses, 32'(m_misses));
      chk("stat_evicts", stat_evicts, 32'(m_evicts));
`endif
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
